// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one execute-stage op, runs a req/gnt/rvalid bus
// transaction for loads and stores, and returns an aligned, extended result.
// Optional macro YSYX_23060201_LSU_MISALIGN_TRAP_EN: when defined, a misaligned
// halfword or word access is trapped without touching the bus.
module ysyx_23060201_lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_load,
  input  logic          in_store,
  input  logic [2:0]    in_func3,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [4:0]    in_rd,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wen,
  output logic [4:0]    out_rd,
  output logic [DW-1:0] out_wdata,
  output logic          out_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          is_store_q, is_store_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic          out_valid_q, out_valid_d, out_wen_q, out_wen_d, out_err_q, out_err_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [DW-1:0] out_wdata_q, out_wdata_d;

  logic          f3_ok, misalign, in_is_mem;
  logic [3:0]    st_mask;
  logic [DW-1:0] st_wdata, ld_data, byte_sh, half_sh;

  assign in_ready  = (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = out_valid_q;
  assign out_wen   = out_wen_q;
  assign out_rd    = out_rd_q;
  assign out_wdata = out_wdata_q;
  assign out_err   = out_err_q;

  // Decode the incoming op: legality, misalignment and store lane placement.
  always_comb begin
    in_is_mem = in_load ^ in_store;
    if (in_store) f3_ok = in_func3 inside {3'b000, 3'b001, 3'b010};
    else          f3_ok = in_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
    misalign = ((in_func3[1:0] == 2'b01) && in_addr[0]) ||
               ((in_func3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Halfwords use {addr[1],0}; words ignore the low address bits.
    case (in_func3[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << in_addr[1:0];
        st_wdata = DW'(in_wdata[7:0]) << {in_addr[1:0], 3'b000};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {in_addr[1], 1'b0};
        st_wdata = DW'(in_wdata[15:0]) << {in_addr[1], 4'b0000};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = in_wdata;
      end
    endcase
  end

  // Extract and extend the loaded lane from the returned word.
  always_comb begin
    byte_sh = mem_rdata >> {off_q, 3'b000};
    half_sh = mem_rdata >> {off_q[1], 4'b0000};
    case (func3_q)
      3'b000:  ld_data = {{(DW-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  ld_data = {{(DW-16){half_sh[15]}}, half_sh[15:0]};
      3'b100:  ld_data = {{(DW-8){1'b0}}, byte_sh[7:0]};
      3'b101:  ld_data = {{(DW-16){1'b0}}, half_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    func3_d     = func3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_valid_d = out_valid_q;
    out_wen_d   = out_wen_q;
    out_rd_d    = out_rd_q;
    out_wdata_d = out_wdata_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          out_rd_d = in_rd;
          if (!in_is_mem) begin
            // Pass-through; both class bits set is flagged but still written.
            state_d     = StResp;
            out_valid_d = 1'b1;
            out_wdata_d = DW'(in_addr);
            out_wen_d   = (in_rd != 5'd0);
            out_err_d   = in_load & in_store;
          end else if (!f3_ok || misalign) begin
            state_d     = StResp;
            out_valid_d = 1'b1;
            out_wdata_d = '0;
            out_wen_d   = 1'b0;
            out_err_d   = 1'b1;
          end else begin
            state_d     = StReq;
            is_store_d  = in_store;
            func3_d     = in_func3;
            off_d       = in_addr[1:0];
            rd_d        = in_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = in_store;
            mem_addr_d  = {in_addr[AW-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wmask_d = st_mask;
          end
        end
      end
      StReq: begin
        if (mem_gnt) begin
          state_d   = StWait;
          mem_req_d = 1'b0;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d     = StResp;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rd_d    = rd_q;
          out_wen_d   = !is_store_q && (rd_q != 5'd0);
          out_wdata_d = is_store_q ? '0 : ld_data;
        end
      end
      StResp: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      out_valid_q <= 1'b0;
      out_wen_q   <= 1'b0;
      out_rd_q    <= 5'd0;
      out_wdata_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_valid_q <= out_valid_d;
      out_wen_q   <= out_wen_d;
      out_rd_q    <= out_rd_d;
      out_wdata_q <= out_wdata_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for ysyx_23060201_lsu: directed scenarios plus
// randomized ops checked against a byte-level reference model.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_func3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the last run_op.
  int          ob_cyc, ob_reqs;
  logic [31:0] ob_maddr, ob_mwdata, ob_owdata;
  logic [3:0]  ob_mask;
  logic        ob_we, ob_wen, ob_err, ob_stable, ob_hold, ob_acc, ob_rdy_after;
  logic [4:0]  ob_rd;

  ysyx_23060201_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_wen(out_wen), .out_rd(out_rd), .out_wdata(out_wdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  // Drives one op from cycle 0 and plays the bus/write-back side with the
  // given grant, rvalid and out_ready delays. Every loop is cycle-bounded.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int gd, input int rvd, input int rdyd, input logic [31:0] rdata);
    int cyc, vcnt, wcnt;
    logic granted, rv_done, done;
    ob_cyc = -1; ob_reqs = 0; ob_stable = 1; ob_hold = 1;
    ob_maddr = 0; ob_mwdata = 0; ob_mask = 0; ob_we = 0;
    ob_owdata = 0; ob_wen = 0; ob_err = 0; ob_rd = 0;
    ob_acc = in_ready;
    in_valid = 1; in_load = ld; in_store = st; in_func3 = f3;
    in_addr = addr; in_wdata = wd; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 0; cyc = 1; vcnt = 0; wcnt = 0; granted = 0; rv_done = 0; done = 0;
    while (!done && cyc < 64) begin
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
      if (mem_req) begin
        if (ob_reqs == 0) begin
          ob_maddr = mem_addr; ob_mwdata = mem_wdata; ob_mask = mem_wmask; ob_we = mem_we;
        end else if ({mem_addr, mem_wdata, mem_wmask, mem_we} !==
                     {ob_maddr, ob_mwdata, ob_mask, ob_we}) begin
          ob_stable = 0;
        end
        if (ob_reqs == gd) begin mem_gnt = 1; granted = 1; end
        ob_reqs++;
      end else if (granted && !rv_done) begin
        if (wcnt == rvd) begin mem_rvalid = 1; mem_rdata = rdata; rv_done = 1; end
        wcnt++;
      end
      if (out_valid) begin
        if (ob_cyc < 0) begin
          ob_cyc = cyc; ob_owdata = out_wdata; ob_wen = out_wen; ob_err = out_err; ob_rd = out_rd;
        end else if ({out_wdata, out_wen, out_err, out_rd} !== {ob_owdata, ob_wen, ob_err, ob_rd})
          ob_hold = 0;
        if (in_ready !== 1'b0) ob_hold = 0;
        if (vcnt == rdyd) begin out_ready = 1; done = 1; end
        vcnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
    ob_rdy_after = in_ready & !out_valid;
  endtask

  task automatic test_reset();
    logic [121:0] all_out;
    #3;
    all_out = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_wen, out_rd,
               out_wdata, out_err, 16'h0};
    n_checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    #5 rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, mem_req, out_valid} !== 3'b100)
      $display("FAIL post_reset_idle: got %b required 100", {in_ready, mem_req, out_valid});
    else n_pass++;
  endtask

  task automatic test_store_sb();
    run_op(0, 1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 5'd7, 0, 0, 0, 32'h0);
    n_checks++;
    if ({ob_maddr, ob_mask, ob_mwdata, ob_we} !== {32'h8000_0000, 4'b1000, 32'hAB00_0000, 1'b1})
      $display("FAIL sb_bus: got addr=%h mask=%b wdata=%h we=%b required 80000000 1000 ab000000 1",
               ob_maddr, ob_mask, ob_mwdata, ob_we);
    else n_pass++;
    n_checks++;
    if ({ob_cyc, ob_wen, ob_err, ob_acc} !== {32'd3, 1'b0, 1'b0, 1'b1})
      $display("FAIL sb_resp: got cyc=%0d wen=%b err=%b acc=%b required 3 0 0 1",
               ob_cyc, ob_wen, ob_err, ob_acc);
    else n_pass++;
  endtask

  task automatic test_load_byte();
    run_op(1, 0, 3'b000, 32'h8000_0001, 32'h0, 5'd3, 0, 0, 0, 32'h0000_8000);
    n_checks++;
    if ({ob_cyc, ob_owdata, ob_wen, ob_rd} !== {32'd3, 32'hFFFF_FF80, 1'b1, 5'd3})
      $display("FAIL lb: got cyc=%0d data=%h wen=%b rd=%0d required 3 ffffff80 1 3",
               ob_cyc, ob_owdata, ob_wen, ob_rd);
    else n_pass++;
    run_op(1, 0, 3'b100, 32'h8000_0001, 32'h0, 5'd3, 0, 0, 0, 32'h0000_8000);
    n_checks++;
    if ({ob_cyc, ob_owdata} !== {32'd3, 32'h0000_0080})
      $display("FAIL lbu: got cyc=%0d data=%h required 3 00000080", ob_cyc, ob_owdata);
    else n_pass++;
  endtask

  task automatic test_lw_stall();
    run_op(1, 0, 3'b010, 32'h8000_0010, 32'h0, 5'd9, 3, 2, 2, 32'hDEAD_BEEF);
    n_checks++;
    if ({ob_cyc, ob_reqs, ob_stable, ob_maddr} !== {32'd8, 32'd4, 1'b1, 32'h8000_0010})
      $display("FAIL lw_stall_bus: got cyc=%0d reqs=%0d stable=%b addr=%h required 8 4 1 80000010",
               ob_cyc, ob_reqs, ob_stable, ob_maddr);
    else n_pass++;
    n_checks++;
    if ({ob_hold, ob_owdata, ob_rdy_after} !== {1'b1, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL lw_stall_out: got hold=%b data=%h ready_after=%b required 1 deadbeef 1",
               ob_hold, ob_owdata, ob_rdy_after);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    run_op(0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    n_checks++;
    if ({ob_cyc, ob_reqs, ob_wen, ob_owdata, ob_err} !== {32'd1, 32'd0, 1'b0, 32'h55, 1'b0})
      $display("FAIL pass_rd0: got cyc=%0d reqs=%0d wen=%b data=%h err=%b required 1 0 0 55 0",
               ob_cyc, ob_reqs, ob_wen, ob_owdata, ob_err);
    else n_pass++;
    run_op(0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd5, 0, 0, 1, 32'h0);
    n_checks++;
    if ({ob_cyc, ob_wen, ob_rd, ob_hold} !== {32'd1, 1'b1, 5'd5, 1'b1})
      $display("FAIL pass_rd5: got cyc=%0d wen=%b rd=%0d hold=%b required 1 1 5 1",
               ob_cyc, ob_wen, ob_rd, ob_hold);
    else n_pass++;
  endtask

  task automatic test_misalign();
    run_op(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd4, 0, 0, 0, 32'h1122_3344);
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
    n_checks++;
    if ({ob_cyc, ob_reqs, ob_err, ob_wen} !== {32'd1, 32'd0, 1'b1, 1'b0})
      $display("FAIL lw_misalign: got cyc=%0d reqs=%0d err=%b wen=%b required 1 0 1 0",
               ob_cyc, ob_reqs, ob_err, ob_wen);
    else n_pass++;
`else
    n_checks++;
    if ({ob_cyc, ob_maddr, ob_err, ob_owdata} !== {32'd3, 32'h8000_0000, 1'b0, 32'h1122_3344})
      $display("FAIL lw_misalign: got cyc=%0d addr=%h err=%b data=%h required 3 80000000 0 11223344",
               ob_cyc, ob_maddr, ob_err, ob_owdata);
    else n_pass++;
`endif
  endtask

  task automatic test_illegal();
    run_op(1, 1, 3'b010, 32'h0000_1234, 32'h0, 5'd6, 0, 0, 0, 32'h0);
    n_checks++;
    if ({ob_cyc, ob_reqs, ob_err, ob_owdata} !== {32'd1, 32'd0, 1'b1, 32'h1234})
      $display("FAIL illegal_class: got cyc=%0d reqs=%0d err=%b data=%h required 1 0 1 1234",
               ob_cyc, ob_reqs, ob_err, ob_owdata);
    else n_pass++;
    run_op(1, 0, 3'b011, 32'h8000_0000, 32'h0, 5'd6, 0, 0, 0, 32'h0);
    n_checks++;
    if ({ob_cyc, ob_reqs, ob_err, ob_wen} !== {32'd1, 32'd0, 1'b1, 1'b0})
      $display("FAIL illegal_f3: got cyc=%0d reqs=%0d err=%b wen=%b required 1 0 1 0",
               ob_cyc, ob_reqs, ob_err, ob_wen);
    else n_pass++;
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, mem_req} !== 3'b010)
      $display("FAIL stray_rvalid: got %b required 010", {out_valid, in_ready, mem_req});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while requesting: mem_req must fall without a clock edge.
    in_valid = 1; in_load = 1; in_store = 0; in_func3 = 3'b010; in_addr = 32'h8000_0020;
    in_rd = 5'd2;
    @(posedge clk); #1;
    in_valid = 0;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL mid_req_up: got %b required 1", mem_req); else n_pass++;
    rst_n = 0; #1;
    n_checks++;
    if ({mem_req, in_ready} !== 2'b01)
      $display("FAIL async_req_drop: got %b required 01", {mem_req, in_ready});
    else n_pass++;
    #1 rst_n = 1;
    // Reset during WAIT, then a late rvalid.
    @(posedge clk); #1;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    rst_n = 0; #1;
    n_checks++;
    if ({mem_req, out_valid, in_ready} !== 3'b001)
      $display("FAIL wait_reset: got %b required 001", {mem_req, out_valid, in_ready});
    else n_pass++;
    #1 rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_req, out_valid, in_ready} !== 3'b001)
      $display("FAIL late_rvalid: got %b required 001", {mem_req, out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int cls, gd, rvd, rdyd, size, eoff, exp_cyc, exp_reqs;
      logic ld, st, legal, mis, exp_err, exp_wen;
      logic [2:0] f3;
      logic [31:0] addr, wd, rdata, exp_mw, exp_data;
      logic [3:0] exp_mask;
      logic [4:0] rd;
      cls = $urandom_range(0, 9);
      ld = (cls == 1) || (cls >= 2 && cls <= 5);
      st = (cls == 1) || (cls >= 6);
      f3 = st && !ld ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      addr = 32'h8000_0000 | $urandom_range(0, 255);
      wd = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3); rdyd = $urandom_range(0, 2);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      eoff = (size == 1) ? int'(addr[1:0]) : (size == 2) ? 2 * int'(addr[1]) : 0;
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
      mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      exp_mask = 0; exp_mw = 0; exp_data = 0;
      for (int i = 0; i < size; i++) begin
        exp_mask[eoff + i] = 1'b1;
        exp_mw[8*(eoff + i) +: 8] = wd[8*i +: 8];
        exp_data[8*i +: 8] = rdata[8*(eoff + i) +: 8];
      end
      if (!f3[2] && size < 4 && exp_data[8*size - 1])
        for (int j = 8 * size; j < 32; j++) exp_data[j] = 1'b1;
      run_op(ld, st, f3, addr, wd, rd, gd, rvd, rdyd, rdata);
      if (ld == st) begin
        exp_cyc = 1; exp_reqs = 0; exp_err = ld; exp_wen = (rd != 0);
        n_checks++;
        if ({ob_cyc, ob_reqs, ob_err, ob_wen, ob_owdata} !== {exp_cyc, exp_reqs, exp_err, exp_wen, addr})
          $display("FAIL rnd_pass[%0d]: got cyc=%0d reqs=%0d err=%b wen=%b data=%h required %0d %0d %b %b %h",
                   it, ob_cyc, ob_reqs, ob_err, ob_wen, ob_owdata, exp_cyc, exp_reqs, exp_err, exp_wen, addr);
        else n_pass++;
      end else if (!legal || mis) begin
        n_checks++;
        if ({ob_cyc, ob_reqs, ob_err, ob_wen} !== {32'd1, 32'd0, 1'b1, 1'b0})
          $display("FAIL rnd_trap[%0d]: got cyc=%0d reqs=%0d err=%b wen=%b required 1 0 1 0",
                   it, ob_cyc, ob_reqs, ob_err, ob_wen);
        else n_pass++;
      end else begin
        exp_cyc = 3 + gd + rvd; exp_reqs = gd + 1;
        exp_wen = ld && (rd != 0);
        n_checks++;
        if ({ob_cyc, ob_reqs, ob_stable, ob_hold, ob_err, ob_wen, ob_rd, ob_maddr, ob_we} !==
            {exp_cyc, exp_reqs, 1'b1, 1'b1, 1'b0, exp_wen, rd, addr & 32'hFFFF_FFFC, st})
          $display("FAIL rnd_mem[%0d]: got cyc=%0d reqs=%0d stable=%b hold=%b err=%b wen=%b rd=%0d addr=%h we=%b required cyc=%0d reqs=%0d wen=%b rd=%0d addr=%h",
                   it, ob_cyc, ob_reqs, ob_stable, ob_hold, ob_err, ob_wen, ob_rd, ob_maddr, ob_we,
                   exp_cyc, exp_reqs, exp_wen, rd, addr & 32'hFFFF_FFFC);
        else n_pass++;
        n_checks++;
        if (st && {ob_mask, ob_mwdata} !== {exp_mask, exp_mw})
          $display("FAIL rnd_store[%0d]: got mask=%b wdata=%h required %b %h",
                   it, ob_mask, ob_mwdata, exp_mask, exp_mw);
        else if (ld && ob_owdata !== exp_data)
          $display("FAIL rnd_load[%0d]: got data=%h required %h", it, ob_owdata, exp_data);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_load = 0; in_store = 0; in_func3 = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
    test_reset();
    test_store_sb();
    test_load_byte();
    test_lw_stall();
    test_passthrough();
    test_misalign();
    test_illegal();
    test_stray_rvalid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
